sram_key_requester: RTL and testbench
=====================================

Name: sram_key_requester

Overview:
- Initiator side of the SRAM OTP key interface.
- Issues a key/nonce request to the OTP key responder, captures the 96-bit `sram_otp_key_rsp_t` response, and presents the key and nonce to the SRAM scrambling datapath with a valid flag.
- Sits inside the SRAM controller, on the same clock as the OTP responder; no CDC.

Parameters:
- KEY_W, 64, width of the key field in the response.
- NONCE_W, 30, width of the nonce field in the response.
- RSP_W, 96, total response width = KEY_W + NONCE_W + 2; elaboration error if inconsistent.
- TIMEOUT_CYC, 1024, cycles to wait for ack before abort (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- renew_i  input  1  single-cycle pulse requesting a fresh key
- sram_otp_key_req_o  output  1  request to OTP responder
- sram_otp_key_i  input  RSP_W  response struct. Bit 0 = ack, bit 1 = seed_valid, [KEY_W+1:2] = key, [RSP_W-1:KEY_W+2] = nonce.
- key_o  output  KEY_W  captured key
- nonce_o  output  NONCE_W  captured nonce
- key_valid_o  output  1  key_o/nonce_o hold a response from the current request
- seed_valid_o  output  1  seed_valid bit captured with the key
- busy_o  output  1  request outstanding
- err_o  output  1  sticky timeout error (tied 0 without the optional feature)

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs become 0.
  - FSM goes to IDLE; the timeout counter is cleared.
- States:
  - IDLE
    - renew_i=1 → REQ.
    - key_valid_o and seed_valid_o are cleared in the same edge.
    - key_o and nonce_o are cleared to 0 in the same edge (no stale key visible).
  - REQ
    - sram_otp_key_req_o=1 and busy_o=1, registered, asserted the cycle after renew_i is sampled.
    - Sample ack each cycle. On ack=1, in that same edge:
      - capture key_o, nonce_o and seed_valid_o from sram_otp_key_i;
      - set key_valid_o=1;
      - go to DONE.
  - DONE
    - req=0 and busy=0 from the cycle after ack.
    - Unconditionally → IDLE next cycle (one-cycle gap before the next request).
- Latency:
  - renew_i sampled at edge N → req high from N+1.
  - Ack sampled at edge M → key_valid_o high and req low from M+1.
- Ack is a single-cycle pulse from the responder. The requester never requires ack to deassert.
- Response bits other than ack are ignored in all cycles where ack=0.
- Ack while in IDLE or DONE is ignored: no capture, no state change.
- renew_i while in REQ or DONE is dropped, not queued. In DONE, a renew_i pulse is lost.
- renew_i and ack in the same cycle in REQ: ack is processed, renew_i is dropped.
- Reset mid-REQ: req drops the following cycle, outputs clear, and a later ack is ignored.
- key_o and nonce_o hold their values until the next accepted renew_i or reset.

Optional Feature:
- Macro: SRAM_KEY_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYC+1) increments each cycle in REQ and clears on entering REQ.
  - When it reaches TIMEOUT_CYC with no ack, the FSM goes to DONE with key_valid_o=0 and sets err_o=1.
  - err_o is sticky until reset or the next accepted renew_i.
  - Ack in the same cycle as the terminal count wins: normal capture, no error.
- When undefined:
  - No counter; REQ waits indefinitely.
  - err_o is constant 0.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0; req never asserts.
- renew_i at cycle 3; responder acks at cycle 7 with key=64'hDEAD_BEEF_0123_4567, nonce=30'h1555_AAAA, seed_valid=1 → req high cycles 4–7; at cycle 8 key_o/nonce_o match, key_valid_o=1, seed_valid_o=1, busy_o=0.
- Second renew_i after first capture → key_valid_o drops and key_o=0 the next cycle. Ack with key=64'h1 and seed_valid=0 → key_o=1, seed_valid_o=0.
- Spurious ack in IDLE with key=64'hFFFF… → no capture; key_valid_o stays 0. renew_i pulsed 3 times during REQ → exactly one request/capture.
- Reset asserted 2 cycles into REQ, ack 3 cycles later → req low after reset edge; no capture; key_valid_o=0.
- With SRAM_KEY_TIMEOUT_EN and TIMEOUT_CYC=16: no ack → at 16 cycles in REQ, req drops, err_o=1, key_valid_o=0. A new renew_i clears err_o; ack at the terminal-count cycle → capture, err_o=0.

Source files
------------

// File: rtl/sram_key_requester.sv
// sram_key_requester: initiator side of the SRAM OTP key interface.
// Issues a key/nonce request to the OTP key responder, captures the response
// on ack and presents key, nonce and seed_valid to the scrambling datapath.
//
// Optional feature macro: SRAM_KEY_TIMEOUT_EN
//   defined   -> REQ aborts after TIMEOUT_CYC cycles without ack, err_o sticky
//   undefined -> REQ waits indefinitely, err_o tied 0
//
// Ports:
//   clk                 clock
//   rst                 synchronous active-high reset
//   renew_i             single-cycle pulse requesting a fresh key
//   sram_otp_key_req_o  request to the OTP responder
//   sram_otp_key_i      response: [0]=ack, [1]=seed_valid,
//                       [KEY_W+1:2]=key, [RSP_W-1:KEY_W+2]=nonce
//   key_o / nonce_o     captured key / nonce
//   key_valid_o         key_o/nonce_o hold the response to the current request
//   seed_valid_o        seed_valid bit captured with the key
//   busy_o              request outstanding
//   err_o               sticky timeout error
module sram_key_requester #(
    parameter int unsigned KEY_W       = 64,
    parameter int unsigned NONCE_W     = 30,
    parameter int unsigned RSP_W       = 96,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               renew_i,
    output logic               sram_otp_key_req_o,
    input  logic [RSP_W-1:0]   sram_otp_key_i,
    output logic [KEY_W-1:0]   key_o,
    output logic [NONCE_W-1:0] nonce_o,
    output logic               key_valid_o,
    output logic               seed_valid_o,
    output logic               busy_o,
    output logic               err_o
);

    // Parameter consistency checks
    if (RSP_W != KEY_W + NONCE_W + 2) begin : g_rsp_w_bad
        $error("sram_key_requester: RSP_W must equal KEY_W + NONCE_W + 2");
    end
    if (TIMEOUT_CYC == 0) begin : g_timeout_bad
        $error("sram_key_requester: TIMEOUT_CYC must be non-zero");
    end

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Response field decode
    logic               rsp_ack;
    logic               rsp_seed;
    logic [KEY_W-1:0]   rsp_key;
    logic [NONCE_W-1:0] rsp_nonce;

    assign rsp_ack   = sram_otp_key_i[0];
    assign rsp_seed  = sram_otp_key_i[1];
    assign rsp_key   = sram_otp_key_i[KEY_W+1:2];
    assign rsp_nonce = sram_otp_key_i[RSP_W-1:KEY_W+2];

    logic [1:0]         state_q, state_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic               kv_q, kv_d;
    logic               sv_q, sv_d;

`ifdef SRAM_KEY_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             err_q, err_d;

    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        kv_d    = kv_q;
        sv_d    = sv_q;
`ifdef SRAM_KEY_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Accepted renew wipes the previous key so nothing stale is visible
                if (renew_i) begin
                    state_d = ST_REQ;
                    key_d   = '0;
                    nonce_d = '0;
                    kv_d    = 1'b0;
                    sv_d    = 1'b0;
`ifdef SRAM_KEY_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                // Ack has priority over a terminal count in the same cycle
                if (rsp_ack) begin
                    state_d = ST_DONE;
                    key_d   = rsp_key;
                    nonce_d = rsp_nonce;
                    sv_d    = rsp_seed;
                    kv_d    = 1'b1;
                end
`ifdef SRAM_KEY_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d  = (state_d == ST_REQ);
        busy_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            key_q   <= '0;
            nonce_q <= '0;
            kv_q    <= 1'b0;
            sv_q    <= 1'b0;
`ifdef SRAM_KEY_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            kv_q    <= kv_d;
            sv_q    <= sv_d;
`ifdef SRAM_KEY_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign sram_otp_key_req_o = req_q;
    assign busy_o             = busy_q;
    assign key_o              = key_q;
    assign nonce_o            = nonce_q;
    assign key_valid_o        = kv_q;
    assign seed_valid_o       = sv_q;
`ifdef SRAM_KEY_TIMEOUT_EN
    assign err_o              = err_q;
`else
    assign err_o              = 1'b0;
`endif

endmodule

// File: tb/tb_sram_key_requester.sv
// Testbench for sram_key_requester: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a reference model.
module tb_sram_key_requester;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        renew = 1'b0;
    logic [95:0] rsp = '0;
    logic        req, kv, sv, busy, err;
    logic [63:0] key;
    logic [29:0] nonce;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_key_requester #(.TIMEOUT_CYC(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .renew_i            (renew),
        .sram_otp_key_req_o (req),
        .sram_otp_key_i     (rsp),
        .key_o              (key),
        .nonce_o            (nonce),
        .key_valid_o        (kv),
        .seed_valid_o       (sv),
        .busy_o             (busy),
        .err_o              (err)
    );

    typedef struct {
        logic        rst;
        logic        renew;
        logic        ack;
        logic        sv_in;
        logic [63:0] key_in;
        logic [29:0] nonce_in;
        logic        e_req;
        logic        e_kv;
        logic        e_sv;
        logic [63:0] e_key;
        logic [29:0] e_nonce;
    } vec_t;

    vec_t vecs[$];

    // Reference model: request outstanding / one dead cycle after completion
    logic        m_req, m_gap, m_kv, m_sv, m_err;
    logic [63:0] m_key;
    logic [29:0] m_nonce;
    int          m_wait;

    function automatic vec_t mk(input logic r, input logic rn, input logic a,
                                input logic s, input logic [63:0] k, input logic [29:0] n,
                                input logic er, input logic ekv, input logic esv,
                                input logic [63:0] ek, input logic [29:0] en);
        vec_t v;
        v.rst = r; v.renew = rn; v.ack = a; v.sv_in = s; v.key_in = k; v.nonce_in = n;
        v.e_req = er; v.e_kv = ekv; v.e_sv = esv; v.e_key = ek; v.e_nonce = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rn, input logic a, input logic s,
                         input logic [63:0] k, input logic [29:0] n);
        rst   = r;
        renew = rn;
        rsp   = {n, k, s, a};
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic er, input logic ekv, input logic esv,
                             input logic [63:0] ek, input logic [29:0] en, input logic eerr);
        chk({tag, ".req"},   64'(req),   64'(er));
        chk({tag, ".busy"},  64'(busy),  64'(er));
        chk({tag, ".kv"},    64'(kv),    64'(ekv));
        chk({tag, ".sv"},    64'(sv),    64'(esv));
        chk({tag, ".key"},   key,        ek);
        chk({tag, ".nonce"}, 64'(nonce), 64'(en));
        chk({tag, ".err"},   64'(err),   64'(eerr));
    endtask

    task automatic model_step(input logic r, input logic rn, input logic a, input logic s,
                              input logic [63:0] k, input logic [29:0] n);
        if (r) begin
            m_req = 0; m_gap = 0; m_kv = 0; m_sv = 0; m_err = 0;
            m_key = '0; m_nonce = '0; m_wait = 0;
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_req) begin
            if (a) begin
                m_key = k; m_nonce = n; m_sv = s; m_kv = 1; m_req = 0; m_gap = 1;
            end else begin
                m_wait++;
`ifdef SRAM_KEY_TIMEOUT_EN
                if (m_wait == int'(TO)) begin
                    m_req = 0; m_gap = 1; m_err = 1;
                end
`endif
            end
        end else if (rn) begin
            m_req = 1; m_wait = 0; m_kv = 0; m_sv = 0; m_err = 0;
            m_key = '0; m_nonce = '0;
        end
    endtask

    localparam logic [63:0] K1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [29:0] N1 = 30'h1555_AAAA;
    localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [29:0] N2 = 30'h0ABC_DEF0;
    localparam logic [63:0] KF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [29:0] NF = 30'h3FFF_FFFF;

    initial begin
        // rst renew ack sv key nonce | req kv sv key nonce (after the edge)
        vecs.push_back(mk(1, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 1, KF, NF,   1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 1, K1, N1,   0, 1, 1, K1, N1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    0, 1, 1, K1, N1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 1, 1, K1, N1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 0, 1,  3,    0, 1, 0, 1,  3));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 1, 0, 1,  3));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 1, KF, NF,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 1, K2, N2,   0, 1, 1, K2, N2));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    0, 1, 1, K2, N2));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 1, 1, K2, N2));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    1, 0, 0, 0,  0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 1, 1, K1, N1,   0, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0,    0, 0, 0, 0,  0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].renew, vecs[i].ack, vecs[i].sv_in,
                  vecs[i].key_in, vecs[i].nonce_in);
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_kv, vecs[i].e_sv,
                      vecs[i].e_key, vecs[i].e_nonce, 1'b0);
        end

`ifdef SRAM_KEY_TIMEOUT_EN
        // Timeout: no ack for TO cycles, then ack exactly at the terminal count
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check_all("to_start", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < int'(TO); i++) drive(0, 0, 0, 0, 0, 0);
        check_all("to_last_wait", 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_all("to_expire", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        check_all("to_sticky", 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        check_all("to_renew_clr", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i < int'(TO); i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, K1, N1);
        check_all("to_ack_wins", 0, 1, 1, K1, N1, 0);
`else
        // Without the timeout feature the request waits indefinitely
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3 * int'(TO); i++) drive(0, 0, 0, 0, 0, 0);
        check_all("no_to_wait", 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, K2, N2);
        check_all("no_to_ack", 0, 1, 0, K2, N2, 0);
`endif

        // Randomized phase against the reference model
        drive(1, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic        r, rn, a, s;
            logic [63:0] k;
            logic [29:0] n;
            r  = ($urandom_range(0, 59) == 0);
            rn = ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, (c < 1500) ? 3 : 24) == 0);
            s  = 1'($urandom);
            k  = {$urandom, $urandom};
            n  = 30'($urandom);
            drive(r, rn, a, s, k, n);
            model_step(r, rn, a, s, k, n);
            check_all($sformatf("rnd%0d", c), m_req, m_kv, m_sv, m_key, m_nonce, m_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
